// File: rtl/vga_plot_arbiter.sv
// Round-robin owner arbiter in front of the single vga_adapter pixel port.
// Define CLEAR_BEFORE_DRAW_EN to sweep the screen to colour 0 before each granted pass.
module vga_plot_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int C_W     = 3,
  parameter int SCR_W   = 160,
  parameter int SCR_H   = 120
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     done_in,
  input  logic [NUM_REQ-1:0]     plot_in,
  input  logic [NUM_REQ*X_W-1:0] x_in,
  input  logic [NUM_REQ*Y_W-1:0] y_in,
  input  logic [NUM_REQ*C_W-1:0] col_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [C_W-1:0]         colour,
  output logic                   plot,
  output logic                   busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] GRANT_LSB = NUM_REQ'(1);

`ifdef CLEAR_BEFORE_DRAW_EN
  typedef enum logic [1:0] {IDLE, CLEAR, OWN, RELEASE} state_t;
`else
  typedef enum logic [1:0] {IDLE, OWN, RELEASE} state_t;
`endif

  state_t         state_reg;
  logic [IW-1:0]  owner_reg;
  logic [IW-1:0]  rr_reg;
  logic [IW-1:0]  pick_idx;
  logic           pick_valid;

  logic [X_W-1:0] x_arr   [NUM_REQ];
  logic [Y_W-1:0] y_arr   [NUM_REQ];
  logic [C_W-1:0] col_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign x_arr[gi]   = x_in[gi*X_W +: X_W];
      assign y_arr[gi]   = y_in[gi*Y_W +: Y_W];
      assign col_arr[gi] = col_in[gi*C_W +: C_W];
    end
  endgenerate

  // Scan downwards so the requester closest after rr_reg is the last (winning) assignment.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(rr_reg) + k) % NUM_REQ]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'((int'(rr_reg) + k) % NUM_REQ);
      end
    end
  end

`ifdef CLEAR_BEFORE_DRAW_EN
  logic [X_W-1:0] clear_x_reg, clear_x_next;
  logic [Y_W-1:0] clear_y_reg, clear_y_next;
  logic           clear_last;

  always_comb begin
    clear_last   = (clear_x_reg == X_W'(SCR_W - 1)) && (clear_y_reg == Y_W'(SCR_H - 1));
    clear_x_next = clear_x_reg + 1'b1;
    clear_y_next = clear_y_reg;
    if (clear_x_reg == X_W'(SCR_W - 1)) begin
      clear_x_next = '0;
      clear_y_next = clear_y_reg + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      rr_reg    <= IW'(NUM_REQ - 1);
      grant     <= '0;
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      plot      <= 1'b0;
      busy      <= 1'b0;
`ifdef CLEAR_BEFORE_DRAW_EN
      clear_x_reg <= '0;
      clear_y_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            owner_reg <= pick_idx;
            rr_reg    <= pick_idx;
            busy      <= 1'b1;
`ifdef CLEAR_BEFORE_DRAW_EN
            // First sweep pixel (0,0) goes out on the same edge that enters CLEAR.
            state_reg <= CLEAR;
            x         <= '0;
            y         <= '0;
            colour    <= '0;
            plot      <= 1'b1;
`else
            state_reg <= OWN;
            grant     <= GRANT_LSB << pick_idx;
`endif
          end
        end
`ifdef CLEAR_BEFORE_DRAW_EN
        CLEAR: begin
          if (clear_last) begin
            clear_x_reg <= '0;
            clear_y_reg <= '0;
            plot        <= 1'b0;
            state_reg   <= OWN;
            grant       <= GRANT_LSB << owner_reg;
          end else begin
            clear_x_reg <= clear_x_next;
            clear_y_reg <= clear_y_next;
            x           <= clear_x_next;
            y           <= clear_y_next;
            plot        <= 1'b1;
          end
        end
`endif
        OWN: begin
          // Done outranks everything; the strobe sampled in the done cycle is dropped.
          if (done_in[owner_reg] || !req[owner_reg]) begin
            state_reg <= RELEASE;
            grant     <= '0;
            plot      <= 1'b0;
          end else begin
            x      <= x_arr[owner_reg];
            y      <= y_arr[owner_reg];
            colour <= col_arr[owner_reg];
            plot   <= plot_in[owner_reg];
          end
        end
        RELEASE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          grant     <= '0;
          plot      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Randomised and directed bench for vga_plot_arbiter against a pass-level reference model.
module tb_vga_plot_arbiter;

  localparam int NR = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int SW = 4;
  localparam int SH = 3;
`ifdef CLEAR_BEFORE_DRAW_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  localparam int GAP = CLR ? 2 + SW*SH : 2;

  localparam int P_IDLE = 0, P_CLEAR = 1, P_OWN = 2, P_REL = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NR-1:0] req, done_in, plot_in;
  logic [NR*XW-1:0] x_in;
  logic [NR*YW-1:0] y_in;
  logic [NR*CW-1:0] col_in;
  logic [NR-1:0] grant;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;
  logic          plot, busy;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int m_phase, m_owner, m_rr, m_pix;
  logic [NR-1:0] e_grant;
  logic [XW-1:0] e_x;
  logic [YW-1:0] e_y;
  logic [CW-1:0] e_col;
  logic          e_plot, e_busy;

  vga_plot_arbiter #(
    .NUM_REQ(NR), .X_W(XW), .Y_W(YW), .C_W(CW), .SCR_W(SW), .SCR_H(SH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .done_in(done_in), .plot_in(plot_in),
    .x_in(x_in), .y_in(y_in), .col_in(col_in), .grant(grant),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Model: a pass is IDLE pick -> (optional raster sweep) -> ownership -> one release cycle.
  task automatic model_edge();
    int found;
    if (!reset_n) begin
      m_phase = P_IDLE; m_rr = NR-1; m_owner = 0; m_pix = 0;
      e_grant = '0; e_x = '0; e_y = '0; e_col = '0; e_plot = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE: begin
          found = -1;
          for (int k = 1; k <= NR; k++)
            if (found < 0 && req[(m_rr + k) % NR]) found = (m_rr + k) % NR;
          if (found >= 0) begin
            m_owner = found;
            m_rr    = found;
            if (CLR) begin
              m_phase = P_CLEAR; m_pix = 0;
              e_x = '0; e_y = '0; e_col = '0; e_plot = 1'b1;
            end else begin
              m_phase = P_OWN;
              e_grant = NR'(1) << found;
            end
          end
        end
        P_CLEAR: begin
          if (m_pix == SW*SH - 1) begin
            e_plot = 1'b0; m_phase = P_OWN; e_grant = NR'(1) << m_owner;
          end else begin
            m_pix++;
            e_x = XW'(m_pix % SW); e_y = YW'(m_pix / SW); e_plot = 1'b1;
          end
        end
        P_OWN: begin
          if (done_in[m_owner] || !req[m_owner]) begin
            m_phase = P_REL; e_grant = '0; e_plot = 1'b0;
          end else begin
            e_x    = x_in[m_owner*XW +: XW];
            e_y    = y_in[m_owner*YW +: YW];
            e_col  = col_in[m_owner*CW +: CW];
            e_plot = plot_in[m_owner];
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
    e_busy = (m_phase != P_IDLE);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("grant", grant, e_grant);
    check("plot", plot, e_plot);
    check("busy", busy, e_busy);
    check("x", x, e_x);
    check("y", y, e_y);
    check("colour", colour, e_col);
  endtask

  task automatic set_engine(input int i, input logic p, input int xv, input int yv, input int cv);
    plot_in[i] = p;
    x_in[i*XW +: XW] = XW'(xv);
    y_in[i*YW +: YW] = YW'(yv);
    col_in[i*CW +: CW] = CW'(cv);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
  endtask

  // Steps until some grant appears; returns the number of grant-free cycles.
  task automatic wait_grant(input string tag, input logic [NR-1:0] exp, output int gap);
    gap = 0;
    while (grant == '0 && gap < 100) begin
      step();
      if (grant == '0) gap++;
    end
    check(tag, grant, exp);
  endtask

  initial begin
    int gap;
    req = '0; done_in = '0; plot_in = '0; x_in = '0; y_in = '0; col_in = '0;

    // 1: reset with all requesting
    req = 4'b1111;
    do_reset();
    check("rst_grant", grant, 0);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    wait_grant("first_grant", 4'b0001, gap);

    // 2: alternating owners 1 and 3
    req = '0; do_reset();
    req = 4'b1010;
    for (int p = 0; p < 3; p++) begin
      wait_grant("alt_grant", (p % 2 == 0) ? 4'b0010 : 4'b1000, gap);
      step(); step();
      done_in = grant;
      step();
      done_in = '0;
      check("alt_release", grant, 0);
    end

    // 3: owner data forwarded, non-owner strobe ignored
    req = '0; do_reset();
    req = 4'b0001;
    wait_grant("own0_grant", 4'b0001, gap);
    set_engine(0, 1'b1, 79, 63, 7);
    set_engine(2, 1'b1, 5, 5, 2);
    step();
    check("fwd_x", x, 79);
    check("fwd_y", y, 63);
    check("fwd_col", colour, 7);
    check("fwd_plot", plot, 1);

    // 4: done and a new request in the same cycle
    done_in = 4'b0001; req = 4'b1001;
    step();
    done_in = '0; req = 4'b1000;
    check("done_drop", grant, 0);
    check("done_plot", plot, 0);
    wait_grant("next_grant", 4'b1000, gap);
    check("grant_gap", gap, GAP - 1);

    // 5: reset mid-pass
    set_engine(3, 1'b1, 12, 34, 5);
    step();
    check("mid_plot", plot, 1);
    reset_n = 1'b0;
    step();
    check("mid_rst_grant", grant, 0);
    check("mid_rst_plot", plot, 0);
    check("mid_rst_x", x, 0);
    check("mid_rst_busy", busy, 0);
    reset_n = 1'b1;

    // Random traffic with held requests, sparse done pulses and occasional resets
    req = '0; plot_in = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
        done_in[i] = ($urandom_range(0, 9) == 0);
        set_engine(i, 1'($urandom), int'($urandom_range(0, 159)),
                   int'($urandom_range(0, 119)), int'($urandom_range(0, 7)));
      end
      reset_n = ($urandom_range(0, 399) != 0);
      step();
    end
    reset_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
